imem_fetch_ctrl: RTL and testbench

Sequences the synchronous-read instruction memory (1-cycle read latency, word-addressed via addr[7:2]) for the IF stage. It owns the PC, issues reads, and tags each returning word with its PC. It also handles hazard stalls (1-entry skid) and branch/jump redirects with squash. Before execution, it grants the memory to the program loader for writes.

---
 rtl/imem_fetch_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// IF-stage sequencer for a synchronous-read instruction memory. The memory has
// a 1-cycle read latency and is word addressed through mem_addr[7:2]. This
// block owns the PC, issues reads, and tags each returning word with the PC it
// was fetched from. A one-entry skid buffer absorbs the word that is already in
// flight when the hazard unit stalls. A redirect (taken branch/jump) squashes
// the in-flight and held words. Out of reset the memory first belongs to the
// program loader (LOAD). Fetching starts after load_done (RUN).
//
// Optional build macro:
//   IMEM_BOOT_BYPASS_EN - reset goes straight to RUN at RESET_PC. LOAD is
//                         unreachable, the write port is tied off and the
//                         loader inputs are unused. The image then comes from
//                         the memory's init file.
//
// Ports:
//   clk            clock; all state changes on posedge
//   reset          asynchronous active-low reset (0 = reset)
//   load_valid     loader write strobe (honoured in LOAD only)
//   load_addr      loader byte address
//   load_data      loader write data
//   load_done      loader finished; start fetching
//   stall          hazard-unit stall of the IF stage
//   redirect_valid branch/jump taken
//   redirect_pc    redirect target (bits [1:0] ignored)
//   mem_addr       memory byte address
//   mem_rd_en      memory read strobe
//   mem_wr_en      memory write strobe
//   mem_wr_data    memory write data
//   mem_rdata      memory read data, valid 1 cycle after mem_rd_en
//   if_valid       instruction valid to IF/ID
//   if_pc          PC of the presented instruction
//   if_instr       presented instruction (NOP_INSTR when if_valid = 0)
//   state          2'b00 LOAD, 2'b01 RUN
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01
  } state_t;

`ifdef IMEM_BOOT_BYPASS_EN
  localparam state_t RESET_STATE = ST_RUN;
`else
  localparam state_t RESET_STATE = ST_LOAD;
`endif

  state_t      r_state;
  logic [31:0] r_pc;           // next fetch address
  logic        r_inflight;     // a read was issued last cycle
  logic [31:0] r_inflight_pc;  // PC of that read
  logic        r_hold_valid;   // skid entry occupied
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic [31:0] r_last_pc;      // PC shown on if_pc while nothing is valid

  logic        w_run;
  logic        w_issue;
  logic        w_pres_valid;
  logic [31:0] w_pres_pc;
  logic [31:0] w_pres_instr;
  logic        w_if_valid;
  logic        w_consume;
  logic        w_capture;

  // The word-align mask drops the low target bits on purpose.
  logic [1:0]  w_unused_redirect_lsb;
  assign w_unused_redirect_lsb = redirect_pc[1:0];

`ifdef IMEM_BOOT_BYPASS_EN
  logic w_unused_loader;
  assign w_unused_loader = ^{load_valid, load_addr, load_data, load_done};
`endif

  // Gating with reset keeps every strobe quiet while reset is asserted, even
  // in the bypass build where the reset state is already RUN.
  assign w_run = (r_state == ST_RUN) && reset;

  // No new read while stalled or redirecting, so at most one word is ever in
  // flight and the single skid entry can never overflow.
  assign w_issue = w_run && !stall && !redirect_valid && !(r_hold_valid && stall);

  // The held word is older than anything in flight, so it is presented first.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_pres_valid = 1'b0;
    w_pres_pc    = r_last_pc;
    w_pres_instr = NOP_INSTR;
    if (r_hold_valid) begin
      w_pres_valid = 1'b1;
      w_pres_pc    = r_hold_pc;
      w_pres_instr = r_hold_instr;
    end else if (r_inflight) begin
      w_pres_valid = 1'b1;
      w_pres_pc    = r_inflight_pc;
      w_pres_instr = mem_rdata;
    end
  end

  // A redirect kills whatever is being presented in the same cycle.
  assign w_if_valid = w_run && w_pres_valid && !redirect_valid;
  assign w_consume  = w_if_valid && !stall;
  // The returning word must be parked when IF/ID cannot take it, because the
  // memory output is only valid for this one cycle.
  assign w_capture  = r_inflight && !r_hold_valid && stall;

  assign if_valid = w_if_valid;
  assign if_pc    = w_if_valid ? w_pres_pc : r_last_pc;
  assign if_instr = w_if_valid ? w_pres_instr : NOP_INSTR;
  assign state    = r_state;

  always_comb begin
    mem_rd_en   = w_issue;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    mem_addr    = '0;
    if (w_run) mem_addr = r_pc;
`ifndef IMEM_BOOT_BYPASS_EN
    else if (reset && r_state == ST_LOAD) begin
      mem_wr_en   = load_valid;
      mem_addr    = load_addr;
      mem_wr_data = load_data;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value of each register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RESET_STATE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
      r_hold_valid  <= 1'b0;
      r_hold_pc     <= RESET_PC;
      r_hold_instr  <= NOP_INSTR;
      r_last_pc     <= RESET_PC;
    end else begin
      case (r_state)
        ST_LOAD: begin
`ifndef IMEM_BOOT_BYPASS_EN
          // A write on the same cycle as load_done still lands, via the
          // combinational write port above.
          if (load_done) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
          end
`endif
        end

        ST_RUN: begin
          if (redirect_valid) begin
            // Squash: the in-flight and held words belong to the wrong path.
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_inflight   <= 1'b0;
            r_hold_valid <= 1'b0;
          end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
              r_pc          <= r_pc + 32'd4;
              r_inflight_pc <= r_pc;
            end
            if (w_capture) begin
              r_hold_valid <= 1'b1;
              r_hold_pc    <= r_inflight_pc;
              r_hold_instr <= mem_rdata;
            end else if (w_consume && r_hold_valid) begin
              r_hold_valid <= 1'b0;
            end
          end
          if (w_if_valid) r_last_pc <= w_pres_pc;
        end

        default: r_state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Directed bench for imem_fetch_ctrl with a behavioural 1-cycle-latency memory.
// Expected (pc, instr) pairs are queued when the stimulus that will produce
// them is driven. A negedge monitor pops one entry for every consumed
// instruction (if_valid && !stall). Inputs change 2 time units after posedge.
// Directed checks sample 1 unit later, and the monitor samples on negedge.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  sb_entry_t sb[$];

  logic [31:0] mem [0:63];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_done      (load_done),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_data    (mem_wr_data),
    .mem_rdata      (mem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .state          (state)
  );

  always #5 clk = ~clk;

  // Memory model: a preset image, a synchronous write and a 1-cycle read.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
  end

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wr_data;
    if (mem_rd_en) mem_rdata <= mem[mem_addr[7:2]];
  end

  // Word the program should see at a byte address. The loader overwrites
  // words 0 and 1 only when the LOAD phase exists.
  function automatic logic [31:0] exp_word(input logic [31:0] a);
`ifdef IMEM_BOOT_BYPASS_EN
    return 32'hC0DE_0000 | a;
`else
    if (a == 32'h0) return 32'hAAAA_0001;
    if (a == 32'h4) return 32'hAAAA_0002;
    return 32'hC0DE_0000 | a;
`endif
  endfunction

  function automatic sb_entry_t mk(input logic [31:0] a);
    sb_entry_t e;
    e.pc    = a;
    e.instr = exp_word(a);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: each consumed instruction must be the next expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
      sb_entry_t e;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL sb_underflow observed pc=0x%08h expected=no instruction", if_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    load_done = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1 reset = 1'b0;
    #1;
`ifdef IMEM_BOOT_BYPASS_EN
    chk("rst_state", 32'(state), 32'h1);
`else
    chk("rst_state", 32'(state), 32'h0);
`endif
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    cyc();
    cyc();

`ifdef IMEM_BOOT_BYPASS_EN
    // Release reset: fetching starts at once, the loader is ignored.
    reset = 1'b1; load_valid = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
    sb.push_back(mk(32'h0)); sb.push_back(mk(32'h4));
    #1;
    chk("byp_state", 32'(state), 32'h1);
    chk("byp_rd_en", 32'(mem_rd_en), 32'h1);
    chk("byp_addr0", mem_addr, 32'h0);
    chk("byp_wr_en", 32'(mem_wr_en), 32'h0);
    chk("byp_wr_data", mem_wr_data, 32'h0);
    cyc(); load_valid = 1'b0; #1;
    chk("byp_first_valid", 32'(if_valid), 32'h1);
    chk("byp_addr4", mem_addr, 32'h4);
    cyc(); #1;
    chk("byp_second_pc", if_pc, 32'h4);
    cyc(); stall = 1'b1; #1;
    chk("byp_third_pc", if_pc, 32'h8);
`else
    reset = 1'b1;
    // LOAD: two loader writes, load_done together with the second one.
    cyc(); load_valid = 1'b1; load_addr = 32'h0; load_data = 32'hAAAA_0001; #1;
    chk("ld0_wr_en", 32'(mem_wr_en), 32'h1);
    chk("ld0_addr", mem_addr, 32'h0);
    chk("ld0_data", mem_wr_data, 32'hAAAA_0001);
    chk("ld0_rd_en", 32'(mem_rd_en), 32'h0);
    chk("ld0_state", 32'(state), 32'h0);
    cyc(); load_addr = 32'h4; load_data = 32'hAAAA_0002; load_done = 1'b1; #1;
    chk("ld1_wr_en", 32'(mem_wr_en), 32'h1);
    chk("ld1_addr", mem_addr, 32'h4);
    chk("ld1_data", mem_wr_data, 32'hAAAA_0002);
    for (int a = 0; a < 24; a += 4) sb.push_back(mk(32'(a)));

    // RUN entry: first read at RESET_PC, loader strobes ignored.
    cyc(); load_done = 1'b0; load_addr = 32'h3C; load_data = 32'hDEAD_BEEF; #1;
    chk("r0_state", 32'(state), 32'h1);
    chk("r0_rd_en", 32'(mem_rd_en), 32'h1);
    chk("r0_addr", mem_addr, 32'h0);
    chk("r0_wr_en", 32'(mem_wr_en), 32'h0);
    chk("r0_if_valid", 32'(if_valid), 32'h0);
    cyc(); load_valid = 1'b0; load_addr = '0; load_data = '0; #1;
    chk("r1_if_valid", 32'(if_valid), 32'h1);
    chk("r1_addr", mem_addr, 32'h4);
    repeat (5) cyc();  // 0x4 .. 0x14 stream out unstalled

    // Redirect to 0x0: the in-flight word at 0x18 is squashed.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0;
    for (int a = 0; a < 16; a += 4) sb.push_back(mk(32'(a)));
    #1;
    chk("rd1_if_valid", 32'(if_valid), 32'h0);
    chk("rd1_rd_en", 32'(mem_rd_en), 32'h0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("rd1_next_rd_en", 32'(mem_rd_en), 32'h1);
    chk("rd1_next_addr", mem_addr, 32'h0);
    chk("rd1_squash", 32'(if_valid), 32'h0);
    cyc();
    cyc();

    // Stall for 3 cycles while 0x8 is presented.
    cyc(); stall = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin cyc(); #1; end
      chk("stl_valid", 32'(if_valid), 32'h1);
      chk("stl_pc", if_pc, 32'h8);
      chk("stl_instr", if_instr, exp_word(32'h8));
      chk("stl_rd_en", 32'(mem_rd_en), 32'h0);
    end
    cyc(); stall = 1'b0; #1;
    chk("rel_pc", if_pc, 32'h8);
    chk("rel_rd_en", 32'(mem_rd_en), 32'h1);
    chk("rel_addr", mem_addr, 32'hC);
    cyc();  // 0xC consumed, 0x10 issued

    // Fill the hold entry with 0x10, then redirect to 0x23 while stalled.
    cyc(); stall = 1'b1; #1;
    chk("hold_pc", if_pc, 32'h10);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h23; sb.push_back(mk(32'h20)); #1;
    chk("rd2_if_valid", 32'(if_valid), 32'h0);
    chk("rd2_rd_en", 32'(mem_rd_en), 32'h0);
    cyc(); redirect_valid = 1'b0; stall = 1'b0; #1;
    chk("rd2_rd_en_next", 32'(mem_rd_en), 32'h1);
    chk("rd2_addr", mem_addr, 32'h20);
    chk("rd2_squash", 32'(if_valid), 32'h0);
    cyc(); #1;
    chk("rd2_target_valid", 32'(if_valid), 32'h1);
    chk("rd2_target_pc", if_pc, 32'h20);

    // Hold 0x24, then reset mid-run.
    cyc(); stall = 1'b1; #1;
    cyc(); #1;
    chk("pre_rst_held_pc", if_pc, 32'h24);
    reset = 1'b0; #1;
    chk("mrst_if_valid", 32'(if_valid), 32'h0);
    chk("mrst_if_instr", if_instr, NOP);
    chk("mrst_state", 32'(state), 32'h0);
    chk("mrst_if_pc", if_pc, 32'h0);
    cyc();
    cyc(); reset = 1'b1; stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("idle_rd_en", 32'(mem_rd_en), 32'h0);
      chk("idle_if_valid", 32'(if_valid), 32'h0);
      chk("idle_state", 32'(state), 32'h0);
    end
    cyc(); load_done = 1'b1; sb.push_back(mk(32'h0)); #1;
    chk("rl_state_load", 32'(state), 32'h0);
    cyc(); load_done = 1'b0; #1;
    chk("rl_state_run", 32'(state), 32'h1);
    chk("rl_rd_en", 32'(mem_rd_en), 32'h1);
    chk("rl_addr", mem_addr, 32'h0);
    cyc(); #1;
    chk("rl_first_valid", 32'(if_valid), 32'h1);
    cyc(); stall = 1'b1; #1;
    chk("rl_second_pc", if_pc, 32'h4);
`endif

    cyc(); #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
